// File: rtl/sik_mem_arbiter_if.sv
// sik_mem_arbiter_if: bundle between the two SIK threads, the arbiter and the
// single-port main memory.
//   Thread n side : reqN/weN/addrN/wdataN/haltN in, ackN/rdataN out
//   Memory side   : mem_en/mem_we/mem_addr/mem_wdata out, mem_rdata in
//   Status        : busy out
// slave  = arbiter view, master = threads + memory view.
interface sik_mem_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          req0, req1;
  logic          we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          halt0, halt1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, halt0, halt1, mem_rdata,
    output ack0, ack1, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, halt0, halt1, mem_rdata,
    input  ack0, ack1, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/sik_mem_arbiter.sv
// sik_mem_arbiter: round-robin arbiter letting SIK threads 0/1 share one
// single-port 64K x 16 memory. One transaction at a time:
//   IDLE -> ISSUE (mem_en pulse) -> WAIT (MEM_LAT cycles) -> RESP (ack pulse).
// Ports:
//   clk   : clock, all state on posedge
//   reset : asynchronous active-low reset
//   bus   : sik_mem_arbiter_if.slave (thread req/ack, memory port, busy)
// All outputs are registered; there is no combinational input->output path.
module sik_mem_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MEM_LAT = 1    // 1..4
) (
  input logic              clk,
  input logic              reset,
  sik_mem_arbiter_if.slave bus
);

  localparam int NT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t                  state_q;
  logic [NT-1:0]           req_w, halt_w, we_w, elig_w;
  logic [NT-1:0][AW-1:0]   addr_w;
  logic [NT-1:0][DW-1:0]   wdata_w;
  logic                    sel_d;
  logic                    gnt_q, last_q, we_q;
  logic [1:0]              cnt_q;
  logic [NT-1:0]           ack_q;
  logic [NT-1:0][DW-1:0]   rdata_q;
  logic                    mem_en_q, mem_we_q, busy_q;
  logic [AW-1:0]           mem_addr_q;
  logic [DW-1:0]           mem_wdata_q;

  assign req_w   = {bus.req1,   bus.req0};
  assign halt_w  = {bus.halt1,  bus.halt0};
  assign we_w    = {bus.we1,    bus.we0};
  assign addr_w  = {bus.addr1,  bus.addr0};
  assign wdata_w = {bus.wdata1, bus.wdata0};
  assign elig_w  = req_w & ~halt_w;

  // Lone requester wins outright; on a tie the thread not served last wins.
  always_comb begin
    sel_d = elig_w[1];
    if (&elig_w) sel_d = ~last_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;   // thread 0 wins the first tie
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      ack_q       <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      // Pulsed outputs default low; they are set for exactly one state.
      ack_q       <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (|elig_w) begin
            // Request fields are captured here; later changes by the thread are ignored.
            gnt_q       <= sel_d;
            last_q      <= sel_d;
            we_q        <= we_w[sel_d];
            mem_en_q    <= 1'b1;
            mem_we_q    <= we_w[sel_d];
            mem_addr_q  <= addr_w[sel_d];
            mem_wdata_q <= wdata_w[sel_d];
            busy_q      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          // Stores wait too so every transaction has the same length.
          cnt_q   <= 2'(MEM_LAT - 1);
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q == 2'd0) begin
            ack_q[gnt_q] <= 1'b1;
            if (!we_q) rdata_q[gnt_q] <= bus.mem_rdata;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        RESP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack0      = ack_q[0];
  assign bus.ack1      = ack_q[1];
  assign bus.rdata0    = rdata_q[0];
  assign bus.rdata1    = rdata_q[1];
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sik_mem_arbiter.sv
// tb_sik_mem_arbiter: directed scenarios on a MEM_LAT=1 and a MEM_LAT=3
// arbiter, then randomized two-thread traffic on the MEM_LAT=1 one, checked
// against a scoreboard of memory contents, issue records and wait bounds.
module tb_sik_mem_arbiter;

  logic clk, reset;
  int   checks = 0, failures = 0;

  sik_mem_arbiter_if #(.AW(16), .DW(16)) ifa ();
  sik_mem_arbiter_if #(.AW(16), .DW(16)) ifb ();

  sik_mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(1)) ua (.clk(clk), .reset(reset), .bus(ifa.slave));
  sik_mem_arbiter #(.AW(16), .DW(16), .MEM_LAT(3)) ub (.clk(clk), .reset(reset), .bus(ifb.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memories: data valid MEM_LAT cycles after the mem_en cycle.
  logic [15:0] mema [0:65535];
  logic [15:0] memb [0:65535];
  logic [15:0] rda;
  logic [2:0][15:0] rdb;

  always @(posedge clk) begin
    if (ifa.mem_en) begin
      if (ifa.mem_we) mema[ifa.mem_addr] <= ifa.mem_wdata;
      rda <= mema[ifa.mem_addr];
    end
  end
  assign ifa.mem_rdata = rda;

  always @(posedge clk) begin
    rdb[2] <= rdb[1];
    rdb[1] <= rdb[0];
    if (ifb.mem_en) begin
      if (ifb.mem_we) memb[ifb.mem_addr] <= ifb.mem_wdata;
      rdb[0] <= memb[ifb.mem_addr];
    end
  end
  assign ifb.mem_rdata = rdb[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    ifa.req0 = 0; ifa.req1 = 0; ifa.we0 = 0; ifa.we1 = 0; ifa.halt0 = 0; ifa.halt1 = 0;
    ifa.addr0 = '0; ifa.addr1 = '0; ifa.wdata0 = '0; ifa.wdata1 = '0;
    ifb.req0 = 0; ifb.req1 = 0; ifb.we0 = 0; ifb.we1 = 0; ifb.halt0 = 0; ifb.halt1 = 0;
    ifb.addr0 = '0; ifb.addr1 = '0; ifb.wdata0 = '0; ifb.wdata1 = '0;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Waits for ackN on ifa, counting negedges from the call; checks latency and data.
  task automatic wait_ack_a(input int thr, input int exp_lat, input logic [15:0] exp_rd,
                            input bit chk_rd, input string tag);
    int n = 0;
    bit got = 0;
    while (!got && n < 20) begin
      @(negedge clk); n++;
      if ((thr == 0) ? ifa.ack0 : ifa.ack1) got = 1;
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_other_ack"}, (thr == 0) ? ifa.ack1 : ifa.ack0, 0);
    if (chk_rd) chk({tag, "_rdata"}, (thr == 0) ? ifa.rdata0 : ifa.rdata1, exp_rd);
  endtask

  // Thread 1 on the MEM_LAT=3 instance, all accesses at 0xFFFF.
  task automatic wait_ack_b(input int exp_lat, input logic [15:0] exp_rd,
                            input bit chk_rd, input string tag);
    int n = 0;
    bit got = 0;
    while (!got && n < 20) begin
      @(negedge clk); n++;
      if (n == 1) begin
        chk({tag, "_en"}, ifb.mem_en, 1);
        chk({tag, "_addr"}, ifb.mem_addr, 16'hFFFF);
      end
      if (ifb.ack1) got = 1;
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_other_ack"}, ifb.ack0, 0);
    if (chk_rd) chk({tag, "_rdata"}, ifb.rdata1, exp_rd);
  endtask

  // Random-phase scoreboard state
  typedef struct { logic we; logic [15:0] addr; logic [15:0] wdata; int cyc; } ev_t;
  ev_t         evq[$];
  ev_t         e;
  bit          pend [2];
  logic        rq_we [2];
  logic [15:0] rq_addr [2];
  logic [15:0] rq_wd [2];
  int          wcnt [2];
  int          oth [2];
  logic [15:0] refm [0:7];
  bit          refv [0:7];

  task automatic drive_req(input int t, input logic r);
    if (t == 0) begin
      ifa.req0 = r; ifa.we0 = rq_we[0]; ifa.addr0 = rq_addr[0]; ifa.wdata0 = rq_wd[0];
    end else begin
      ifa.req1 = r; ifa.we1 = rq_we[1]; ifa.addr1 = rq_addr[1]; ifa.wdata1 = rq_wd[1];
    end
  endtask

  initial begin
    int order [4];
    int k, coinc, cyc, nacks;
    logic acc_a, acc_b, acc_c;
    logic [1:0] a;
    bit abort;

    clear_inputs();
    pulse_reset();

    // Reset state
    chk("rst_ack0", ifa.ack0, 0);
    chk("rst_ack1", ifa.ack1, 0);
    chk("rst_mem_en", ifa.mem_en, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_rdata0", ifa.rdata0, 0);
    chk("rst_mem_addr", ifa.mem_addr, 0);

    // 1: reset in the middle of ISSUE drops the transaction
    ifa.req0 = 1; ifa.we0 = 0; ifa.addr0 = 16'h0005;
    @(negedge clk);
    chk("t1_issue", ifa.mem_en, 1);
    reset = 1'b0;
    #1;
    chk("t1_rst_mem_en", ifa.mem_en, 0);
    chk("t1_rst_busy", ifa.busy, 0);
    ifa.req0 = 0;
    acc_a = 0;
    repeat (2) begin @(negedge clk); acc_a |= ifa.ack0; end
    reset = 1'b1;
    repeat (6) begin @(negedge clk); acc_a |= ifa.ack0; end
    chk("t1_no_ack", acc_a, 0);

    // 2: store then load, same address
    pulse_reset();
    ifa.req0 = 1; ifa.we0 = 1; ifa.addr0 = 16'h0010; ifa.wdata0 = 16'hBEEF;
    wait_ack_a(0, 3, 16'h0, 0, "t2_st");
    ifa.we0 = 0;   // req stays high: new request seen in the following IDLE
    wait_ack_a(0, 4, 16'hBEEF, 1, "t2_ld");
    ifa.req0 = 0;

    // 3: both requesting from reset release
    reset = 1'b0;
    ifa.req0 = 1; ifa.we0 = 0; ifa.addr0 = 16'h0010;
    ifa.req1 = 1; ifa.we1 = 0; ifa.addr1 = 16'h0010;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) order[i] = 9;
    k = 0; coinc = 0;
    for (int n = 0; n < 60 && k < 4; n++) begin
      @(negedge clk);
      if (ifa.ack0 && ifa.ack1) coinc++;
      else if (ifa.ack0) begin order[k] = 0; chk("t3_rdata0", ifa.rdata0, 16'hBEEF); k++; end
      else if (ifa.ack1) begin order[k] = 1; chk("t3_rdata1", ifa.rdata1, 16'hBEEF); k++; end
    end
    ifa.req0 = 0; ifa.req1 = 0;
    chk("t3_coincide", coinc, 0);
    chk("t3_order0", order[0], 0);
    chk("t3_order1", order[1], 1);
    chk("t3_order2", order[2], 0);
    chk("t3_order3", order[3], 1);

    // 4: halted thread is ignored until halt drops
    ifa.halt1 = 1; ifa.req1 = 1; ifa.we1 = 0; ifa.addr1 = 16'h0010;
    acc_a = 0; acc_b = 0;
    repeat (6) begin @(negedge clk); acc_a |= ifa.mem_en; acc_b |= ifa.busy; end
    chk("t4_halt_no_en", acc_a, 0);
    chk("t4_halt_idle", acc_b, 0);
    ifa.halt1 = 0;
    wait_ack_a(1, 3, 16'hBEEF, 1, "t4");
    ifa.req1 = 0;

    // 6: req dropped right after grant still completes exactly once
    @(negedge clk);
    ifa.req0 = 1; ifa.we0 = 0; ifa.addr0 = 16'h0010;
    @(negedge clk);
    chk("t6_issue", ifa.mem_en, 1);
    ifa.req0 = 0;
    @(negedge clk);
    @(negedge clk);
    chk("t6_ack", ifa.ack0, 1);
    chk("t6_rdata", ifa.rdata0, 16'hBEEF);
    acc_a = 0; acc_b = 0; acc_c = 0;
    repeat (6) begin
      @(negedge clk); acc_a |= ifa.ack0; acc_b |= ifa.mem_en; acc_c |= ifa.busy;
    end
    chk("t6_single_ack", acc_a, 0);
    chk("t6_no_regrant", acc_b, 0);
    chk("t6_idle", acc_c, 0);

    // 5: MEM_LAT=3, address 0xFFFF
    @(negedge clk);
    ifb.req1 = 1; ifb.we1 = 1; ifb.addr1 = 16'hFFFF; ifb.wdata1 = 16'h1234;
    wait_ack_b(5, 16'h0, 0, "t5_st");
    ifb.req1 = 0;
    @(negedge clk);
    ifb.req1 = 1; ifb.we1 = 0;
    wait_ack_b(5, 16'h1234, 1, "t5_ld");
    ifb.req1 = 0;

    // Randomized traffic on the MEM_LAT=1 instance
    pulse_reset();
    for (int i = 0; i < 8; i++) refv[i] = 0;
    for (int t = 0; t < 2; t++) begin pend[t] = 0; wcnt[t] = 0; oth[t] = 0; end
    cyc = 0; nacks = 0; abort = 0;
    for (int c = 0; c < 700 && !abort; c++) begin
      @(negedge clk); cyc++;
      a = {ifa.ack1, ifa.ack0};
      if (ifa.mem_en) begin
        e.we = ifa.mem_we; e.addr = ifa.mem_addr; e.wdata = ifa.mem_wdata; e.cyc = cyc;
        evq.push_back(e);
      end
      if (a != 2'b00) chk("rnd_ack_excl", a == 2'b11, 0);
      for (int t = 0; t < 2; t++) begin
        if (pend[t]) wcnt[t]++;
        if (a[t]) begin
          nacks++;
          chk("rnd_ack_pending", pend[t], 1);
          if (evq.size() == 0) chk("rnd_ev_present", 0, 1);
          else begin
            e = evq.pop_front();
            chk("rnd_issue_to_ack", cyc - e.cyc, 2);
            chk("rnd_mem_we", e.we, rq_we[t]);
            chk("rnd_mem_addr", e.addr, rq_addr[t]);
            if (rq_we[t]) chk("rnd_mem_wdata", e.wdata, rq_wd[t]);
          end
          if (rq_we[t]) begin
            refm[rq_addr[t][2:0]] = rq_wd[t];
            refv[rq_addr[t][2:0]] = 1;
          end else if (refv[rq_addr[t][2:0]]) begin
            chk("rnd_rdata", (t == 0) ? ifa.rdata0 : ifa.rdata1, refm[rq_addr[t][2:0]]);
          end
          chk("rnd_wait_bound", wcnt[t] <= 7, 1);
          chk("rnd_fair", oth[t] <= 1, 1);
          if (pend[1-t]) oth[1-t]++;
          pend[t] = 0;
          drive_req(t, 1'b0);
        end else if (pend[t]) begin
          if (wcnt[t] > 30) begin
            chk("rnd_timeout", wcnt[t], 7);
            abort = 1;
          end
        end else if (c < 600 && $urandom_range(0, 2) == 0) begin
          pend[t] = 1; wcnt[t] = 0; oth[t] = 0;
          rq_we[t] = 1'($urandom_range(0, 1));
          rq_addr[t] = 16'($urandom_range(0, 7));
          rq_wd[t] = 16'($urandom);
          drive_req(t, 1'b1);
        end
      end
    end
    chk("rnd_drained", {30'd0, pend[1], pend[0]}, 0);
    chk("rnd_evq_empty", evq.size(), 0);
    chk("rnd_activity", nacks > 40, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
